// File: rtl/jpeg_output_blk_fifo_if.sv
// Write/read handshake bundle for the JPEG output block FIFO.
// The FIFO side uses the slave modport; producer/consumer logic uses master.
interface jpeg_output_blk_fifo_if #(
  parameter int WIDTH  = 32,
  parameter int BLOCKS = 8
);
  localparam int LW = $clog2(BLOCKS) + 1;

  logic             flush_i;
  logic [5:0]       wr_idx_i;
  logic [WIDTH-1:0] data_in_i;
  logic             push_i;
  logic             accept_o;
  logic [WIDTH-1:0] data_out_o;
  logic             v_o;
  logic             yumi_i;
  logic             blk_last_o;
  logic [LW-1:0]    level_o;

  modport slave (
    input  flush_i, wr_idx_i, data_in_i, push_i, yumi_i,
    output accept_o, data_out_o, v_o, blk_last_o, level_o
  );

  modport master (
    output flush_i, wr_idx_i, data_in_i, push_i, yumi_i,
    input  accept_o, data_out_o, v_o, blk_last_o, level_o
  );
endinterface

// File: rtl/jpeg_output_blk_fifo.sv
// Block-granular FIFO: 64-word blocks are written in any word order, committed
// after 64 accepted pushes, then streamed out in address order with a stall-safe output.
module jpeg_output_blk_fifo #(
  parameter int WIDTH  = 32,
  parameter int BLOCKS = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  jpeg_output_blk_fifo_if.slave bus
);
  localparam int BW    = $clog2(BLOCKS);
  localparam int AW    = BW + 6;
  localparam int LW    = BW + 1;
  localparam int DEPTH = BLOCKS * 64;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [5:0]       wcnt_q, wcnt_d;
  logic [BW:0]      wblk_q, wblk_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ov_q, ov_d;
  logic             olast_q, olast_d;
  logic [WIDTH-1:0] odata_q;

  logic accept, push_ok, commit, consume, release_blk, avail, issue;

  assign accept      = (level_q < LW'(BLOCKS));
  assign push_ok     = bus.push_i & accept & ~bus.flush_i;
  assign commit      = push_ok & (wcnt_q == 6'd63);
  assign consume     = ov_q & bus.yumi_i & ~bus.flush_i;
  assign release_blk = consume & olast_q;
  // A block becomes readable only once the write block pointer has moved past it.
  assign avail       = (rptr_q[AW:6] != wblk_q);
  // Refill the output register when it is empty or being taken this cycle.
  assign issue       = avail & (~ov_q | consume) & ~bus.flush_i;

  always_comb begin
    wcnt_d  = wcnt_q;
    wblk_d  = wblk_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ov_d    = ov_q;
    olast_d = olast_q;
    if (bus.flush_i) begin
      wcnt_d  = '0;
      wblk_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ov_d    = 1'b0;
      olast_d = 1'b0;
    end else begin
      if (push_ok) wcnt_d = wcnt_q + 6'd1;
      if (commit)  wblk_d = wblk_q + 1'b1;
      if (issue) begin
        rptr_d  = rptr_q + 1'b1;
        ov_d    = 1'b1;
        olast_d = &rptr_q[5:0];
      end else if (consume) begin
        ov_d    = 1'b0;
        olast_d = 1'b0;
      end
      unique case ({commit, release_blk})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q  <= '0;
      wblk_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ov_q    <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wblk_q  <= wblk_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ov_q    <= ov_d;
      olast_q <= olast_d;
    end
  end

  // RAM write port and registered read port; the read register only loads on
  // issue, so it doubles as the stall-holding output stage.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[{wblk_q[BW-1:0], bus.wr_idx_i}] <= bus.data_in_i;
  end

  always_ff @(posedge clk_i) begin
    if (issue) odata_q <= mem[rptr_q[AW-1:0]];
  end

  assign bus.accept_o   = accept;
  assign bus.v_o        = ov_q;
  assign bus.data_out_o = ov_q ? odata_q : '0;
  assign bus.blk_last_o = ov_q & olast_q;
  assign bus.level_o    = level_q;
endmodule

// File: tb/tb_jpeg_output_blk_fifo.sv
// Bench for jpeg_output_blk_fifo: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, and a BLOCKS=2 wrap stream.
module tb_jpeg_output_blk_fifo;
  localparam int W  = 32;
  localparam int B  = 8;
  localparam int B2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jpeg_output_blk_fifo_if #(.WIDTH(W), .BLOCKS(B))  bus  ();
  jpeg_output_blk_fifo_if #(.WIDTH(W), .BLOCKS(B2)) bus2 ();

  jpeg_output_blk_fifo #(.WIDTH(W), .BLOCKS(B))  dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  jpeg_output_blk_fifo #(.WIDTH(W), .BLOCKS(B2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model (BLOCKS=8 instance) ----------------
  typedef struct {
    logic [W-1:0] d;
    bit           last;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] mmem [B*64];
  int           mwcnt = 0, mwblk = 0, mlevel = 0;
  bit           mv = 0, ml = 0;
  logic [W-1:0] md = '0;

  always @(posedge clk or posedge rst) begin
    bit   rel, com;
    ent_t e;
    if (rst || bus.flush_i) begin
      mq.delete();
      mv = 0; ml = 0; md = '0;
      mwcnt = 0; mwblk = 0; mlevel = 0;
    end else begin
      rel = mv && bus.yumi_i && ml;
      // Words committed before this edge are the only ones eligible for output.
      if (!mv || bus.yumi_i) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          mv = 1; md = e.d; ml = e.last;
        end else begin
          mv = 0; md = '0; ml = 0;
        end
      end
      com = 0;
      if (bus.push_i && mlevel < B) begin
        mmem[mwblk*64 + int'(bus.wr_idx_i)] = bus.data_in_i;
        mwcnt++;
        if (mwcnt == 64) begin
          for (int k = 0; k < 64; k++) begin
            e.d = mmem[mwblk*64 + k];
            e.last = (k == 63);
            mq.push_back(e);
          end
          mwcnt = 0;
          mwblk = (mwblk + 1) % B;
          com = 1;
        end
      end
      mlevel = mlevel + int'(com) - int'(rel);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit           chk_en = 0;
  logic         pv = 0, py = 0, pf = 0;
  logic [W-1:0] pd = '0;
  logic [W-1:0] seen[$];

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("v_o",        64'(bus.v_o),        64'(mv));
      chk("data_out_o", 64'(bus.data_out_o), 64'(md));
      chk("blk_last_o", 64'(bus.blk_last_o), 64'(ml));
      chk("level_o",    64'(bus.level_o),    64'(mlevel));
      chk("accept_o",   64'(bus.accept_o),   64'(mlevel < B));
      if (pv && !py && !pf) chk("stall_hold", 64'(bus.data_out_o), 64'(pd));
      if (bus.v_o && bus.yumi_i) seen.push_back(bus.data_out_o);
      pv = bus.v_o; py = bus.yumi_i; pf = bus.flush_i; pd = bus.data_out_o;
    end else begin
      pv = 0;
    end
  end

  // ---------------- BLOCKS=2 stream checker ----------------
  int n2_rx = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus2.v_o && bus2.yumi_i) begin
        chk("b2_data", 64'(bus2.data_out_o), 64'(W'(n2_rx) ^ 32'h5A000000));
        chk("b2_last", 64'(bus2.blk_last_o), 64'(n2_rx % 64 == 63));
        n2_rx++;
      end
      if (!bus2.v_o) chk("b2_idle_zero", 64'({bus2.data_out_o, bus2.blk_last_o}), 64'd0);
      if (bus2.level_o > 2) chk("b2_level_max", 64'(bus2.level_o), 64'd2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push_i = 0; bus.yumi_i = 0; bus.flush_i = 0;
    bus.wr_idx_i = '0; bus.data_in_i = '0;
  endtask

  task automatic consume_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.yumi_i = bus.v_o;
      step();
    end
    bus.yumi_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int n_push;
    bit done;
    idle();
    bus2.push_i = 0; bus2.yumi_i = 0; bus2.flush_i = 0;
    bus2.wr_idx_i = '0; bus2.data_in_i = '0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_v",      64'(bus.v_o),        64'd0);
    chk("rst_data",   64'(bus.data_out_o), 64'd0);
    chk("rst_last",   64'(bus.blk_last_o), 64'd0);
    chk("rst_level",  64'(bus.level_o),    64'd0);
    chk("rst_accept", 64'(bus.accept_o),   64'd1);
    rst = 0;
    chk_en = 1;
    step();

    // Reverse-order block, data equals index, consumer always ready.
    for (int k = 0; k < 64; k++) begin
      bus.push_i = 1; bus.wr_idx_i = 6'(63 - k); bus.data_in_i = W'(63 - k);
      step();
    end
    bus.push_i = 0;
    chk("rev_v_at_commit",  64'(bus.v_o),     64'd0);
    chk("rev_level_commit", 64'(bus.level_o), 64'd1);
    step();
    chk("rev_v_rise",  64'(bus.v_o),        64'd1);
    chk("rev_first",   64'(bus.data_out_o), 64'd0);
    seen.delete();
    consume_n(64);
    chk("rev_count", 64'(seen.size()), 64'd64);
    for (int i = 0; i < 64 && i < seen.size(); i++) chk("rev_order", 64'(seen[i]), 64'(i));
    chk("rev_level_end", 64'(bus.level_o), 64'd0);

    // Fill all 8 blocks without consuming.
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 64; k++) begin
        bus.push_i = 1; bus.wr_idx_i = 6'(k); bus.data_in_i = W'((b << 8) | k) ^ 32'hA5A50000;
        step();
      end
    chk("full_accept", 64'(bus.accept_o), 64'd0);
    chk("full_level",  64'(bus.level_o),  64'd8);
    bus.wr_idx_i = 6'd3; bus.data_in_i = 32'hDEADBEEF;
    step();
    bus.push_i = 0;
    chk("full_ignore_level", 64'(bus.level_o), 64'd8);
    consume_n(64);
    chk("free_accept", 64'(bus.accept_o), 64'd1);
    chk("free_level",  64'(bus.level_o),  64'd7);
    consume_n(192);
    chk("drain_to4", 64'(bus.level_o), 64'd4);

    // Commit and last-word release on the same edge.
    for (int k = 0; k < 64; k++) begin
      bus.push_i = 1; bus.wr_idx_i = 6'(k); bus.data_in_i = $urandom;
      bus.yumi_i = bus.v_o;
      step();
    end
    bus.push_i = 0; bus.yumi_i = 0;
    chk("same_edge_level",  64'(bus.level_o),  64'd4);
    chk("same_edge_accept", 64'(bus.accept_o), 64'd1);

    // Throttled consumer across three more blocks, scrambled word order.
    seen.delete();
    for (int k = 0; k < 192; k++) begin
      bus.push_i = 1; bus.wr_idx_i = 6'((k * 37) % 64); bus.data_in_i = $urandom;
      bus.yumi_i = bus.v_o & 1'($urandom_range(0, 1));
      step();
    end
    bus.push_i = 0;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      bus.yumi_i = bus.v_o & 1'($urandom_range(0, 1));
      step();
      done = (bus.level_o == 0) && !bus.v_o;
    end
    bus.yumi_i = 0;
    chk("throttle_drained", 64'(done), 64'd1);
    chk("throttle_count",   64'(seen.size()), 64'd448);

    // Flush mid-block with push and yumi asserted.
    for (int k = 0; k < 84; k++) begin
      bus.push_i = 1; bus.wr_idx_i = 6'(k % 64); bus.data_in_i = W'(32'h300 + k);
      bus.yumi_i = bus.v_o;
      step();
    end
    bus.flush_i = 1; bus.yumi_i = bus.v_o;
    step();
    idle();
    chk("flush_v",      64'(bus.v_o),        64'd0);
    chk("flush_data",   64'(bus.data_out_o), 64'd0);
    chk("flush_level",  64'(bus.level_o),    64'd0);
    chk("flush_accept", 64'(bus.accept_o),   64'd1);

    // Block 0 after flush, with a duplicated index (word 5 written twice, word 10 skipped).
    for (int k = 0; k < 64; k++) begin
      bus.push_i = 1; bus.wr_idx_i = (k == 10) ? 6'd5 : 6'(k); bus.data_in_i = W'(32'hD000 + k);
      step();
    end
    bus.push_i = 0;
    step();
    chk("dup_v",     64'(bus.v_o),        64'd1);
    chk("dup_first", 64'(bus.data_out_o), 64'h0000D000);
    seen.delete();
    consume_n(64);
    chk("dup_count", 64'(seen.size()), 64'd64);
    if (seen.size() == 64) begin
      chk("dup_last_wins", 64'(seen[5]),  64'h0000D00A);
      chk("dup_word63",    64'(seen[63]), 64'h0000D03F);
    end

    // Asynchronous reset while reading the second of three queued blocks.
    for (int k = 0; k < 192; k++) begin
      bus.push_i = 1; bus.wr_idx_i = 6'(k % 64); bus.data_in_i = W'(32'h7000 + k);
      step();
    end
    bus.push_i = 0;
    consume_n(74);
    bus.yumi_i = bus.v_o;
    #2 rst = 1;
    #1;
    chk("arst_v",      64'(bus.v_o),        64'd0);
    chk("arst_data",   64'(bus.data_out_o), 64'd0);
    chk("arst_last",   64'(bus.blk_last_o), 64'd0);
    chk("arst_level",  64'(bus.level_o),    64'd0);
    chk("arst_accept", 64'(bus.accept_o),   64'd1);
    idle();
    step();
    step();
    rst = 0;
    step();
    for (int k = 0; k < 64; k++) begin
      bus.push_i = 1; bus.wr_idx_i = 6'(k); bus.data_in_i = W'(32'hE000 + k);
      step();
    end
    bus.push_i = 0;
    step();
    chk("post_rst_v",     64'(bus.v_o),        64'd1);
    chk("post_rst_first", 64'(bus.data_out_o), 64'h0000E000);
    consume_n(64);

    // 20 blocks through the BLOCKS=2 instance.
    n_push = 0;
    for (int c = 0; c < 8000 && n2_rx < 1280; c++) begin
      bus2.push_i    = (n_push < 1280) && bus2.accept_o;
      bus2.wr_idx_i  = 6'(n_push % 64);
      bus2.data_in_i = W'(n_push) ^ 32'h5A000000;
      bus2.yumi_i    = bus2.v_o & ($urandom_range(0, 3) != 0);
      step();
      if (bus2.push_i) n_push++;
    end
    bus2.push_i = 0; bus2.yumi_i = 0;
    chk("b2_words", 64'(n2_rx), 64'd1280);
    step();
    chk("b2_level_end", 64'(bus2.level_o), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
